// File: rtl/riscv_pkg.sv
// Shared processor parameters and data-memory arbitration types.
// XLEN/DMEM_SIZE are the existing core settings; the arbiter types sit beside them.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int DMEM_SIZE = 1024;
    localparam int DMEM_AW   = $clog2(DMEM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } dmem_arb_state_t;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic               we;
        logic [XLEN-1:0]    wdata;
    } dmem_req_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: combinational read, write on the rising clock edge.
// Lives beside the arbiter at processor top.
module data_memory
    import riscv_pkg::*;
(
    input  logic                         clk,
    input  logic [$clog2(DMEM_SIZE)-1:0] data_addr,
    input  logic [XLEN-1:0]              data_write_data,
    input  logic                         data_write_enable,
    output logic [XLEN-1:0]              data_read_data
);

    logic [XLEN-1:0] mem [DMEM_SIZE];

    always_ff @(posedge clk) begin
        if (data_write_enable) begin
            mem[data_addr] <= data_write_data;
        end
    end

    assign data_read_data = mem[data_addr];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core LSU (port 0) and DMA/loader (port 1) share
// one single-cycle RAM port, with bounded bursts and round-robin on ties.
//
//   state | meaning
//   IDLE  | nothing accepted last cycle, no owner
//   OWN0  | port 0 accepted last cycle, beat_cnt counts its run
//   OWN1  | port 1 accepted last cycle, beat_cnt counts its run
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int  MAX_BURST = 4,
    localparam int AW        = $clog2(DMEM_SIZE)
) (
    input  logic            clk,
    input  logic            rst_ni,

    input  logic            p0_valid,
    output logic            p0_ready,
    input  logic [AW-1:0]   p0_addr,
    input  logic            p0_we,
    input  logic [XLEN-1:0] p0_wdata,
    output logic            p0_rsp_valid,
    output logic [XLEN-1:0] p0_rdata,

    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [AW-1:0]   p1_addr,
    input  logic            p1_we,
    input  logic [XLEN-1:0] p1_wdata,
    output logic            p1_rsp_valid,
    output logic [XLEN-1:0] p1_rdata,

    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    dmem_arb_state_t state;
    logic [3:0]      beat_cnt;
    logic            rr_pref;
    logic [1:0]      rsp_valid;
    logic [XLEN-1:0] rdata_q [2];

    dmem_req_t req [2];
    dmem_req_t sel;
    logic [1:0] vld;
    logic       gnt_any;
    logic       gnt_id;
    logic       burst_left;
    logic       owner_hit;

    always_comb begin
        req[0] = '{addr: p0_addr, we: p0_we, wdata: p0_wdata};
        req[1] = '{addr: p1_addr, we: p1_we, wdata: p1_wdata};
    end

    // Requests are masked during reset so nothing reaches the RAM.
    assign vld        = {p1_valid, p0_valid} & {2{rst_ni}};
    assign burst_left = (beat_cnt < MAX_B);

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == OWN0 && vld[0] && (burst_left || !vld[1])) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
        end else if (state == OWN1 && vld[1] && (burst_left || !vld[0])) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
        end else if (vld[0] && vld[1]) begin
            gnt_any = 1'b1;
            gnt_id  = rr_pref;
        end else if (vld[0] || vld[1]) begin
            gnt_any = 1'b1;
            gnt_id  = vld[1];
        end
    end

    assign sel       = req[gnt_id];
    assign owner_hit = (state == OWN0 && !gnt_id) || (state == OWN1 && gnt_id);

    assign p0_ready  = gnt_any && !gnt_id;
    assign p1_ready  = gnt_any &&  gnt_id;
    assign mem_addr  = gnt_any ? sel.addr  : '0;
    assign mem_wdata = gnt_any ? sel.wdata : '0;
    assign mem_we    = gnt_any && sel.we;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            beat_cnt   <= 4'd0;
            rr_pref    <= 1'b0;
            rsp_valid  <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (gnt_any) begin
                state             <= gnt_id ? OWN1 : OWN0;
                rr_pref           <= ~gnt_id;
                beat_cnt          <= (owner_hit && burst_left) ? beat_cnt + 4'd1 : 4'd1;
                rsp_valid[gnt_id] <= 1'b1;
                rdata_q[gnt_id]   <= sel.we ? '0 : mem_rdata;
            end else begin
                state    <= IDLE;
                beat_cnt <= 4'd0;
            end
        end
    end

    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];

endmodule
